hpu_cfg_master: RTL

AXI4-Lite initiator that programs and sequences the HPU accelerator's register window: configuration writes, a `gen` phase polled to completion, the `run` phase, and shutdown on request. It sits between a local controller (start/stop strobes plus configuration values) and the accelerator's AXI-Lite slave port. With it, the HPU can be launched from fabric logic without a processor on the control path.

---
 rtl/hpu_cfg_master.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hpu_cfg_master.sv
// hpu_cfg_master: AXI4-Lite initiator that configures and sequences the HPU register window.
// It writes the configuration registers, sets gen, polls status bit 0 until gen clears,
// sets run, and on request clears the control register again.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN    clock, asynchronous active-low reset
//   start, stop                  one-cycle control strobes
//   cfg_item_num .. cfg_even     configuration, sampled when start is accepted
//   busy, running, error         status; err_code 01 BRESP, 10 RRESP, 11 poll timeout
//   M_AXI_AW*/W*/B*/AR*/R*       AXI4-Lite master channels (all outputs registered)
module hpu_cfg_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_MAX  = 1024,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] cfg_item_num,
  input  logic [19:0] cfg_addr_j,
  input  logic [19:0] cfg_addr_i,
  input  logic [4:0]  cfg_remainder,
  input  logic        cfg_even,
  output logic        busy,
  output logic        running,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [3:0] {
    StIdle, StWr, StWb, StPollWait, StRa, StRd, StRunning, StStopWr, StStopWb, StDone, StErr
  } state_e;

  localparam logic [1:0]  ErrBresp = 2'b01;
  localparam logic [1:0]  ErrRresp = 2'b10;
  localparam logic [1:0]  ErrPoll  = 2'b11;
  localparam logic [31:0] CtrlGen  = 32'd1;
  localparam logic [31:0] CtrlRun  = 32'd2;
  // The poll counter is 16 bits, so the timeout limit saturates there; 0 behaves like 1.
  localparam int unsigned PollLimit = (POLL_MAX == 0) ? 1 :
                                      ((POLL_MAX > 65535) ? 65535 : POLL_MAX);

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] item_q, item_d;
  logic [19:0] addr_j_q, addr_j_d;
  logic [19:0] addr_i_q, addr_i_d;
  logic [4:0]  rem_q, rem_d;
  logic        even_q, even_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] araddr_q, araddr_d;

  logic [2:0]  nxt_step;
  logic [7:0]  nxt_off;
  logic [31:0] nxt_data;
  logic        aw_pending, w_pending;
  logic        unused_rdata;

  // Only status bit 0 (gen) is inspected; the rest is folded into a sink.
  assign unused_rdata = ^M_AXI_RDATA[31:1];

  assign aw_pending = awvalid_q && !M_AXI_AWREADY;
  assign w_pending  = wvalid_q && !M_AXI_WREADY;

  // Register/data of the configuration write following the current step.
  always_comb begin
    nxt_step = step_q + 3'd1;
    nxt_off  = 8'h00;
    nxt_data = 32'd0;
    case (nxt_step)
      3'd1: begin nxt_off = 8'h08; nxt_data = {12'd0, addr_j_q}; end
      3'd2: begin nxt_off = 8'h0C; nxt_data = {12'd0, addr_i_q}; end
      3'd3: begin nxt_off = 8'h10; nxt_data = {27'd0, rem_q};    end
      3'd4: begin nxt_off = 8'h14; nxt_data = {31'd0, even_q};   end
      3'd5: begin nxt_off = 8'h00; nxt_data = CtrlGen;           end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    item_d     = item_q;
    addr_j_d   = addr_j_q;
    addr_i_d   = addr_i_q;
    rem_d      = rem_q;
    even_d     = even_q;
    err_code_d = err_code_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    araddr_d   = araddr_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          item_d     = cfg_item_num;
          addr_j_d   = cfg_addr_j;
          addr_i_d   = cfg_addr_i;
          rem_d      = cfg_remainder;
          even_d     = cfg_even;
          err_code_d = 2'b00;
          step_d     = 3'd0;
          state_d    = StWr;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = BASE_ADDR + 32'h04;
          wdata_d    = {16'd0, cfg_item_num};
        end
      end
      StWr, StStopWr: begin
        // AW and W retire independently; move on once neither is still waiting.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!aw_pending && !w_pending) begin
          bready_d = 1'b1;
          state_d  = (state_q == StWr) ? StWb : StStopWb;
        end
      end
      StWb: begin
        if (bready_q && M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            state_d    = StErr;
            err_code_d = ErrBresp;
          end else if (step_q == 3'd5) begin
            poll_cnt_d = 16'd0;
            if (POLL_GAP == 0) begin
              state_d   = StRa;
              arvalid_d = 1'b1;
              araddr_d  = BASE_ADDR;
            end else begin
              state_d   = StPollWait;
              gap_cnt_d = 16'd0;
            end
          end else if (step_q == 3'd6) begin
            state_d = StRunning;
          end else begin
            step_d    = nxt_step;
            state_d   = StWr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = BASE_ADDR + {24'd0, nxt_off};
            wdata_d   = nxt_data;
          end
        end
      end
      StPollWait: begin
        if (32'(gap_cnt_q) + 32'd1 >= POLL_GAP) begin
          state_d   = StRa;
          arvalid_d = 1'b1;
          araddr_d  = BASE_ADDR;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      StRa: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRd;
        end
      end
      StRd: begin
        if (rready_q && M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (M_AXI_RRESP != 2'b00) begin
            state_d    = StErr;
            err_code_d = ErrRresp;
          end else if (!M_AXI_RDATA[0]) begin
            step_d    = 3'd6;
            state_d   = StWr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = BASE_ADDR;
            wdata_d   = CtrlRun;
          end else if (32'(poll_cnt_q) + 32'd1 >= PollLimit) begin
            state_d    = StErr;
            err_code_d = ErrPoll;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            if (POLL_GAP == 0) begin
              state_d   = StRa;
              arvalid_d = 1'b1;
              araddr_d  = BASE_ADDR;
            end else begin
              state_d   = StPollWait;
              gap_cnt_d = 16'd0;
            end
          end
        end
      end
      StRunning: begin
        if (stop) begin
          state_d   = StStopWr;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = BASE_ADDR;
          wdata_d   = 32'd0;
        end
      end
      StStopWb: begin
        if (bready_q && M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            state_d    = StErr;
            err_code_d = ErrBresp;
          end else begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= StIdle;
      step_q     <= 3'd0;
      item_q     <= 16'd0;
      addr_j_q   <= 20'd0;
      addr_i_q   <= 20'd0;
      rem_q      <= 5'd0;
      even_q     <= 1'b0;
      err_code_q <= 2'b00;
      poll_cnt_q <= 16'd0;
      gap_cnt_q  <= 16'd0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= 32'd0;
      wdata_q    <= 32'd0;
      araddr_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      item_q     <= item_d;
      addr_j_q   <= addr_j_d;
      addr_i_q   <= addr_i_d;
      rem_q      <= rem_d;
      even_q     <= even_d;
      err_code_q <= err_code_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      araddr_q   <= araddr_d;
    end
  end

  assign busy     = !(state_q inside {StIdle, StRunning, StDone, StErr});
  assign running  = (state_q == StRunning);
  assign error    = (state_q == StErr);
  assign err_code = err_code_q;

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hf;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
